irq_ctrl_mc: RTL and testbench
==============================

Name: irq_ctrl_mc

Overview:
Parametrised multi-source interrupt controller between peripheral IRQ lines (pkt SRAM, CAN, UART, timers) and the core's 32-bit irq vector.
- Per source: 2-flop input synchroniser, edge or level mode, enable, sticky pending bit.
- Pending bits clear on core acknowledge (irq_ack_i/irq_id_i) or by write-1-to-clear from a small config register port.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..16).
IRQ_BASE, 16, bit index in irq_o and IRQ ID of source 0; IRQ_BASE+NUM_SRC <= 32.
ID_W, 5, width of irq_id_i.

Ports:
clk_i  in  1  single clock.
rst_i  in  1  synchronous reset, active-high.
irq_i  in  NUM_SRC  raw peripheral IRQ lines, asynchronous.
irq_o  out  32  interrupt vector to core.
irq_ack_i  in  1  core acknowledges the interrupt named by irq_id_i.
irq_id_i  in  ID_W  ID being acknowledged.
cfg_we_i  in  1  config write strobe.
cfg_addr_i  in  2  register select: 0 ENABLE, 1 MODE, 2 PENDING, 3 RAW.
cfg_wdata_i  in  32  write data; bits [NUM_SRC-1:0] used.
cfg_rdata_o  out  32  combinational read of the register at cfg_addr_i; unused bits read 0.

Behaviour:
- Reset (rst_i high at a clock edge): sync flops, prev flops, ENABLE, MODE, pending and irq_o all go to 0. After reset, ENABLE=0 and every source is in level mode.
- Synchroniser: s1 <= irq_i; s2 <= s1; prev <= s2.
  - Edge event: s2 & ~prev.
  - A line held high across reset release produces exactly one edge event.
- Pending set condition per source i:
  - MODE[i]=1 (edge): set on an edge event.
  - MODE[i]=0 (level): set whenever s2[i]=1.
- Pending clear conditions:
  - irq_ack_i=1 and irq_id_i == IRQ_BASE+i.
  - Config write to addr 2 with cfg_wdata_i[i]=1.
- Set and clear in the same cycle: set wins, so no event is lost.
  - Level mode: a source still high re-pends the cycle after ack.
- irq_id_i outside [IRQ_BASE, IRQ_BASE+NUM_SRC-1]: ignored.
- Output: irq_o[IRQ_BASE+i] <= pending[i] & ENABLE[i], registered. All other irq_o bits are constant 0.
- Latency: irq_i rising before edge k gives pending=1 after edge k+2 and irq_o=1 after edge k+3. Ack at edge a clears irq_o after edge a+1.
- ENABLE=0 masks output only: pending still accumulates and is presented once enabled.
- Changing MODE does not touch pending.
- Config writes:
  - Addr 0/1 load ENABLE/MODE from cfg_wdata_i[NUM_SRC-1:0].
  - Addr 3 writes are ignored.
  - Reads: ENABLE, MODE, pending, s2.

Optional Feature:
IRQ_CTRL_PRIO_EN.
- Defined: irq_o carries at most one bit, for the lowest-index source with pending & ENABLE (fixed priority). Other pending sources wait. After the ack clears the winner, the next winner appears on irq_o one cycle later.
- Undefined: all pending & enabled sources are presented simultaneously.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register address constants ADDR_ENABLE=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_RAW=3;
  - mode encodings MODE_LEVEL=0, MODE_EDGE=1;
  - default IRQ_BASE=16 and NUM_SRC max=16.
- One sub-module, irq_src_cell: per-source synchroniser, edge detect and pending flop with set-wins logic, instantiated NUM_SRC times.
- Top level holds the config registers, ack decode, output register and optional priority encoder.

Test Plan:
1. Reset, ENABLE=0xF, MODE=0xF; pulse irq_i[1] high for 1 cycle at k -> irq_o[17]=1 from k+3, stays 1; ack with id 17 -> irq_o[17]=0 next cycle.
2. MODE[0]=0, irq_i[0] held high; ack id 16 -> irq_o[16] drops for exactly 1 cycle, then reasserts; release irq_i[0] then ack -> stays 0.
3. Ack id 18 issued in the same cycle a new edge on source 2 reaches the pending flop -> pending[2] remains 1 and irq_o[18] stays high.
4. ENABLE=0, pulse irq_i[3] -> irq_o=0, cfg read addr 2 = 0x8; write ENABLE=0x8 -> irq_o[19]=1 one cycle later; write 0x8 to addr 2 -> cleared.
5. IRQ_CTRL_PRIO_EN defined: pend sources 1 and 3 together -> irq_o=0x00020000; ack 17 -> irq_o=0x00080000 next cycle.
6. Assert rst_i with all sources pending -> irq_o=0, cfg reads all 0 after edge; ack id 5 and id 31 -> no effect.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the irq_ctrl_mc interrupt controller: register map,
// source mode encodings and parameter limits.
package irq_ctrl_pkg;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_RAW     = 2'd3;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam int unsigned DEF_IRQ_BASE = 16;
    localparam int unsigned MAX_NUM_SRC  = 16;
    localparam int unsigned VEC_W        = 32;

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: 2-flop synchroniser, rising-edge detect and sticky
// pending flop.
module irq_src_cell
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic mode,
    input  logic clr,
    output logic pending,
    output logic raw
);

    logic s1;
    logic s2;
    logic prev;
    logic rise;
    logic edge_set;
    logic level_set;
    logic pend_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            s1      <= irq;
            s2      <= s1;
            prev    <= s2;
            pending <= pend_nxt;
        end
    end

    // An edge arriving with a clear survives; a level source is cleared and
    // simply re-pends on the following cycle while the line is still high.
    always_comb begin
        rise      = s2 & ~prev;
        edge_set  = (mode == MODE_EDGE) & rise;
        level_set = (mode == MODE_LEVEL) & s2;
        pend_nxt  = edge_set | ((level_set | pending) & ~clr);
    end

    assign raw = s2;

endmodule

// File: rtl/irq_ctrl_mc.sv
// Multi-source interrupt controller: config registers, ack decode and the
// registered irq vector. Define IRQ_CTRL_PRIO_EN for fixed-priority output.
module irq_ctrl_mc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned IRQ_BASE = DEF_IRQ_BASE,
    parameter int unsigned ID_W     = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_SRC-1:0]  irq_i,
    output logic [VEC_W-1:0]    irq_o,
    input  logic                irq_ack_i,
    input  logic [ID_W-1:0]     irq_id_i,
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_addr_i,
    input  logic [VEC_W-1:0]    cfg_wdata_i,
    output logic [VEC_W-1:0]    cfg_rdata_o
);

    if (NUM_SRC < 1 || NUM_SRC > MAX_NUM_SRC || IRQ_BASE + NUM_SRC > VEC_W) begin : g_bad_cfg
        $error("irq_ctrl_mc: illegal NUM_SRC/IRQ_BASE combination");
    end

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] present;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata_i[VEC_W-1:NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_src_cell u_cell (
            .clk     (clk_i),
            .rst     (rst_i),
            .irq     (irq_i[g]),
            .mode    (mode[g]),
            .clr     (clr[g]),
            .pending (pending[g]),
            .raw     (raw[g])
        );
    end

    // Ack IDs outside this controller's window match no source and are ignored.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = (irq_ack_i && (VEC_W'(irq_id_i) == VEC_W'(IRQ_BASE + i)))
                  || (cfg_we_i && (cfg_addr_i == ADDR_PENDING) && cfg_wdata_i[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable <= '0;
            mode   <= '0;
        end else if (cfg_we_i) begin
            if (cfg_addr_i == ADDR_ENABLE) enable <= cfg_wdata_i[NUM_SRC-1:0];
            if (cfg_addr_i == ADDR_MODE)   mode   <= cfg_wdata_i[NUM_SRC-1:0];
        end
    end

    // Priority build keeps only the lowest-index active source (x & -x).
    always_comb begin
        active = pending & enable;
`ifdef IRQ_CTRL_PRIO_EN
        present = active & (~active + NUM_SRC'(1));
`else
        present = active;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) irq_o <= '0;
        else       irq_o <= VEC_W'(present) << IRQ_BASE;
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:  cfg_rdata_o = VEC_W'(enable);
            ADDR_MODE:    cfg_rdata_o = VEC_W'(mode);
            ADDR_PENDING: cfg_rdata_o = VEC_W'(pending);
            ADDR_RAW:     cfg_rdata_o = VEC_W'(raw);
            default:      cfg_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl_mc.sv
// Self-checking bench for irq_ctrl_mc: per-cycle expected irq_o values are
// queued with each stimulus and popped as the DUT advances.
module tb_irq_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic [31:0] irq_vec;
    logic        ack;
    logic [4:0]  id;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_vec = 0;
    int          n_err = 0;

`ifdef IRQ_CTRL_PRIO_EN
    localparam logic [31:0] P13 = 32'h0002_0000;
    localparam logic [31:0] PALL = 32'h0001_0000;
`else
    localparam logic [31:0] P13 = 32'h000A_0000;
    localparam logic [31:0] PALL = 32'h000F_0000;
`endif

    irq_ctrl_mc dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_i       (irq),
        .irq_o       (irq_vec),
        .irq_ack_i   (ack),
        .irq_id_i    (id),
        .cfg_we_i    (we),
        .cfg_addr_i  (addr),
        .cfg_wdata_i (wdata),
        .cfg_rdata_o (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = '0; ack = 1'b0; id = '0; we = 1'b0; addr = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_vec++;
        if (irq_vec !== e) begin n_err++; $display("FAIL reset irq_o: got %h want %h", irq_vec, e); end
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1; n_vec++;
            if (rdata !== 32'h0) begin n_err++; $display("FAIL reset rdata[%0d]: got %h want 0", a, rdata); end
        end
    endtask

    task automatic test_edge_pulse();
        cfg_write(2'd0, 32'hF);
        cfg_write(2'd1, 32'hF);
        irq[1] = 1'b1;
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) irq = '0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL edge_pulse c%0d: got %h want %h", c, irq_vec, e); end
        end
        ack = 1'b1; id = 5'd17;
        exp_q = '{32'h0002_0000, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) ack = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL edge_ack c%0d: got %h want %h", c, irq_vec, e); end
        end
    endtask

    task automatic test_level();
        cfg_write(2'd1, 32'hE);
        irq[0] = 1'b1;
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL level_hold c%0d: got %h want %h", c, irq_vec, e); end
        end
        ack = 1'b1; id = 5'd16;
        exp_q = '{32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0001_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) ack = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL level_reack c%0d: got %h want %h", c, irq_vec, e); end
        end
        irq[0] = 1'b0;
        exp_q = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL level_sticky c%0d: got %h want %h", c, irq_vec, e); end
        end
        ack = 1'b1; id = 5'd16;
        exp_q = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) ack = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL level_release c%0d: got %h want %h", c, irq_vec, e); end
        end
    endtask

    task automatic test_ack_set_collision();
        irq[2] = 1'b1;
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            case (c)
                0: irq[2] = 1'b0;
                1: irq[2] = 1'b1;
                2: irq[2] = 1'b0;
                3: begin ack = 1'b1; id = 5'd18; end
                4: ack = 1'b0;
                default: ;
            endcase
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL collision c%0d: got %h want %h", c, irq_vec, e); end
        end
        addr = 2'd2; #1; n_vec++;
        if (rdata !== 32'h4) begin n_err++; $display("FAIL collision pending: got %h want 00000004", rdata); end
        we = 1'b1; addr = 2'd2; wdata = 32'h4;
        exp_q = '{32'h0004_0000, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) begin we = 1'b0; wdata = '0; end
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL w1c_src2 c%0d: got %h want %h", c, irq_vec, e); end
        end
    endtask

    task automatic test_enable_mask();
        cfg_write(2'd0, 32'h7);
        irq[3] = 1'b1;
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) irq = '0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL masked c%0d: got %h want %h", c, irq_vec, e); end
        end
        addr = 2'd2; #1; n_vec++;
        if (rdata !== 32'h8) begin n_err++; $display("FAIL masked pending: got %h want 00000008", rdata); end
        we = 1'b1; addr = 2'd0; wdata = 32'h8;
        exp_q = '{32'h0, 32'h0008_0000, 32'h0008_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) begin we = 1'b0; wdata = '0; end
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL unmask c%0d: got %h want %h", c, irq_vec, e); end
        end
        we = 1'b1; addr = 2'd2; wdata = 32'h8;
        exp_q = '{32'h0008_0000, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) begin we = 1'b0; wdata = '0; end
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL w1c_src3 c%0d: got %h want %h", c, irq_vec, e); end
        end
    endtask

    task automatic test_priority();
        cfg_write(2'd0, 32'hF);
        irq = 4'b1010;
        exp_q = '{32'h0, 32'h0, 32'h0, P13, P13};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) irq = '0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL prio_both c%0d: got %h want %h", c, irq_vec, e); end
        end
        ack = 1'b1; id = 5'd17;
        exp_q = '{P13, 32'h0008_0000, 32'h0008_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) ack = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL prio_next c%0d: got %h want %h", c, irq_vec, e); end
        end
        we = 1'b1; addr = 2'd2; wdata = 32'h8;
        exp_q = '{32'h0008_0000, 32'h0, 32'h0};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) begin we = 1'b0; wdata = '0; end
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL prio_clear c%0d: got %h want %h", c, irq_vec, e); end
        end
    endtask

    task automatic test_reset_pending_and_bad_ids();
        cfg_write(2'd1, 32'hF);
        irq = 4'hF;
        exp_q = '{32'h0, 32'h0, 32'h0, PALL, PALL};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) irq = '0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL all_pend c%0d: got %h want %h", c, irq_vec, e); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (irq_vec !== 32'h0) begin n_err++; $display("FAIL rst_irq_o: got %h want 0", irq_vec); end
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1; n_vec++;
            if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata[%0d]: got %h want 0", a, rdata); end
        end
        cfg_write(2'd1, 32'hF);
        cfg_write(2'd0, 32'hF);
        irq[0] = 1'b1;
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick(); if (c == 0) irq = '0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL repend c%0d: got %h want %h", c, irq_vec, e); end
        end
        ack = 1'b1; id = 5'd5;
        exp_q = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        for (int c = 0; exp_q.size() > 0; c++) begin
            tick();
            if (c == 0) id = 5'd31;
            if (c == 1) ack = 1'b0;
            e = exp_q.pop_front(); n_vec++;
            if (irq_vec !== e) begin n_err++; $display("FAIL bad_id c%0d: got %h want %h", c, irq_vec, e); end
        end
        addr = 2'd2; #1; n_vec++;
        if (rdata !== 32'h1) begin n_err++; $display("FAIL bad_id pending: got %h want 00000001", rdata); end
    endtask

    initial begin
        test_reset();
        test_edge_pulse();
        test_level();
        test_ack_set_collision();
        test_enable_mask();
        test_priority();
        test_reset_pending_and_bad_ids();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
